// File: rtl/id_pipelined_pkg.sv
// Shared definitions for the id_pipelined decode stage.
//  - instruction/PC widths and ALU operator/category encodings
//  - opcode and function-field constants for the supported ISA subset
//  - decode_t plus the decode() helper, which maps one instruction word
//    onto operator, category, register reads/write and immediate.
package id_pipelined_pkg;

  localparam int INST_ADDR_WIDTH      = 32;
  localparam int INST_DATA_WIDTH      = 32;
  localparam int ALU_OPERATOR_WIDTH   = 8;
  localparam int ALU_CATEGORY_WIDTH   = 3;
  localparam int FWD_CHANNELS_DEFAULT = 2;

  typedef enum logic [ALU_OPERATOR_WIDTH-1:0] {
    ALU_NOP = 8'h00,
    ALU_OR  = 8'h25,
    ALU_AND = 8'h24,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27,
    ALU_SLL = 8'h7C,
    ALU_SRL = 8'h02,
    ALU_SRA = 8'h03
  } alu_operator_e;

  typedef enum logic [ALU_CATEGORY_WIDTH-1:0] {
    CAT_NOP   = 3'b000,
    CAT_LOGIC = 3'b001,
    CAT_SHIFT = 3'b010
  } alu_category_e;

  // Primary opcodes [31:26]
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL function field [5:0]
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  typedef struct packed {
    logic          known;      // encoding belongs to the supported subset
    alu_operator_e op;
    alu_category_e cat;
    logic          read_en1;
    logic [4:0]    read_reg1;
    logic          read_en2;
    logic [4:0]    read_reg2;
    logic          write_en;
    logic [4:0]    write_reg;
    logic [31:0]   imm;        // value used by a disabled read port
  } decode_t;

  function automatic decode_t decode(input logic [INST_DATA_WIDTH-1:0] inst);
    decode_t    d;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    opcode = inst[31:26];
    rs     = inst[25:21];
    rt     = inst[20:16];
    rd     = inst[15:11];
    sa     = inst[10:6];
    funct  = inst[5:0];

    d           = '0;
    d.read_reg1 = rs;
    d.read_reg2 = rt;

    case (opcode)
      OP_SPECIAL: begin
        // Register-register forms require a zero shamt field.
        if (sa == 5'd0) begin
          case (funct)
            FN_OR:   begin d.known = 1'b1; d.op = ALU_OR;  d.cat = CAT_LOGIC; end
            FN_AND:  begin d.known = 1'b1; d.op = ALU_AND; d.cat = CAT_LOGIC; end
            FN_XOR:  begin d.known = 1'b1; d.op = ALU_XOR; d.cat = CAT_LOGIC; end
            FN_NOR:  begin d.known = 1'b1; d.op = ALU_NOR; d.cat = CAT_LOGIC; end
            FN_SLLV: begin d.known = 1'b1; d.op = ALU_SLL; d.cat = CAT_SHIFT; end
            FN_SRLV: begin d.known = 1'b1; d.op = ALU_SRL; d.cat = CAT_SHIFT; end
            FN_SRAV: begin d.known = 1'b1; d.op = ALU_SRA; d.cat = CAT_SHIFT; end
            FN_SYNC: d.known = 1'b1;
            default: ;
          endcase
          if (d.known && funct != FN_SYNC) begin
            d.read_en1  = 1'b1;
            d.read_en2  = 1'b1;
            d.write_en  = 1'b1;
            d.write_reg = rd;
          end
        end
        // Immediate shifts: rs must be zero, shamt feeds operand 1.
        if (rs == 5'd0 && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)) begin
          d.known     = 1'b1;
          d.cat       = CAT_SHIFT;
          d.op        = (funct == FN_SLL) ? ALU_SLL : (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
          d.read_en2  = 1'b1;
          d.write_en  = 1'b1;
          d.write_reg = rd;
          d.imm       = {27'd0, sa};
        end
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        d.known     = 1'b1;
        d.cat       = CAT_LOGIC;
        d.op        = (opcode == OP_ORI) ? ALU_OR : (opcode == OP_ANDI) ? ALU_AND : ALU_XOR;
        d.read_en1  = 1'b1;
        d.write_en  = 1'b1;
        d.write_reg = rt;
        d.imm       = {16'd0, inst[15:0]};
      end
      OP_LUI: begin
        // rs | (imm << 16); canonical LUI has rs = $0.
        d.known     = 1'b1;
        d.cat       = CAT_LOGIC;
        d.op        = ALU_OR;
        d.read_en1  = 1'b1;
        d.write_en  = 1'b1;
        d.write_reg = rt;
        d.imm       = {inst[15:0], 16'd0};
      end
      OP_PREF: d.known = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_pipelined_operand_forward.sv
// operand_forward: selects one ID operand.
//  read_enable/read_addr/read_result : register-file port being resolved
//  imm                               : value used when the port is disabled
//  fwd_write_enable/addr/data/ready  : N write-back channels, channel 0 youngest
//  operand                           : resolved operand value
//  not_ready                         : winning channel has no data yet (load-use)
module operand_forward #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_CHANNELS   = 2
) (
  input  logic                                 read_enable,
  input  logic [REG_ADDR_WIDTH-1:0]            read_addr,
  input  logic [DATA_WIDTH-1:0]                read_result,
  input  logic [DATA_WIDTH-1:0]                imm,
  input  logic [FWD_CHANNELS-1:0]              fwd_write_enable,
  input  logic [FWD_CHANNELS*REG_ADDR_WIDTH-1:0] fwd_write_addr,
  input  logic [FWD_CHANNELS*DATA_WIDTH-1:0]   fwd_write_data,
  input  logic [FWD_CHANNELS-1:0]              fwd_data_ready,
  output logic [DATA_WIDTH-1:0]                operand,
  output logic                                 not_ready
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    operand   = read_result;
    not_ready = 1'b0;
    if (!read_enable) begin
      operand = imm;
    end else if (read_addr == '0) begin
      operand = '0;  // $0 is hard-wired; writes to it are never forwarded
    end else begin
      // Scan oldest to youngest so the lowest matching channel is written last and wins.
      for (int i = FWD_CHANNELS - 1; i >= 0; i--) begin
        if (fwd_write_enable[i] && fwd_write_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == read_addr) begin
          operand   = fwd_write_data[i*DATA_WIDTH +: DATA_WIDTH];
          not_ready = ~fwd_data_ready[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_pipelined.sv
// id_pipelined: decode stage between IF/ID and EX.
//  clock, reset (sync, active-high), flush, stall_in, if_valid
//  program_counter, instruction            : instruction currently in ID
//  fwd_write_enable/addr/data/data_ready   : N forwarding channels, 0 = youngest
//  read_result1/2 -> read_enable1/2, read_addr1/2 : register-file ports
//  stall_request                           : hold PC and IF/ID
//  ex_*                                    : registered ID/EX stage
//  stall_count                             : saturating count of hazard bubbles
module id_pipelined
  import id_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FWD_CHANNELS    = FWD_CHANNELS_DEFAULT,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   stall_in,
  input  logic                                   if_valid,
  input  logic [INST_ADDR_WIDTH-1:0]             program_counter,
  input  logic [INST_DATA_WIDTH-1:0]             instruction,
  input  logic [FWD_CHANNELS-1:0]                fwd_write_enable,
  input  logic [FWD_CHANNELS*REG_ADDR_WIDTH-1:0] fwd_write_addr,
  input  logic [FWD_CHANNELS*DATA_WIDTH-1:0]     fwd_write_data,
  input  logic [FWD_CHANNELS-1:0]                fwd_data_ready,
  input  logic [DATA_WIDTH-1:0]                  read_result1,
  input  logic [DATA_WIDTH-1:0]                  read_result2,
  output logic                                   read_enable1,
  output logic                                   read_enable2,
  output logic [REG_ADDR_WIDTH-1:0]              read_addr1,
  output logic [REG_ADDR_WIDTH-1:0]              read_addr2,
  output logic                                   stall_request,
  output logic                                   ex_valid,
  output logic [INST_ADDR_WIDTH-1:0]             ex_program_counter,
  output logic [ALU_OPERATOR_WIDTH-1:0]          ex_alu_operator,
  output logic [ALU_CATEGORY_WIDTH-1:0]          ex_alu_category,
  output logic [DATA_WIDTH-1:0]                  ex_alu_operand1,
  output logic [DATA_WIDTH-1:0]                  ex_alu_operand2,
  output logic                                   ex_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]              ex_write_addr,
  output logic                                   ex_invalid,
  output logic [STALL_CNT_WIDTH-1:0]             stall_count
);

  decode_t               dec;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic                  not_ready1;
  logic                  not_ready2;
  logic                  hazard;
  logic                  do_bubble;
  logic                  do_load;
  logic                  do_count;

  assign dec          = decode(instruction);
  assign imm          = DATA_WIDTH'(dec.imm);
  assign read_enable1 = dec.read_en1;
  assign read_enable2 = dec.read_en2;
  assign read_addr1   = REG_ADDR_WIDTH'(dec.read_reg1);
  assign read_addr2   = REG_ADDR_WIDTH'(dec.read_reg2);

  operand_forward #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .FWD_CHANNELS  (FWD_CHANNELS)
  ) u_forward1 (
    .read_enable     (read_enable1),
    .read_addr       (read_addr1),
    .read_result     (read_result1),
    .imm             (imm),
    .fwd_write_enable(fwd_write_enable),
    .fwd_write_addr  (fwd_write_addr),
    .fwd_write_data  (fwd_write_data),
    .fwd_data_ready  (fwd_data_ready),
    .operand         (operand1),
    .not_ready       (not_ready1)
  );

  operand_forward #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .FWD_CHANNELS  (FWD_CHANNELS)
  ) u_forward2 (
    .read_enable     (read_enable2),
    .read_addr       (read_addr2),
    .read_result     (read_result2),
    .imm             (imm),
    .fwd_write_enable(fwd_write_enable),
    .fwd_write_addr  (fwd_write_addr),
    .fwd_write_data  (fwd_write_data),
    .fwd_data_ready  (fwd_data_ready),
    .operand         (operand2),
    .not_ready       (not_ready2)
  );

  assign hazard        = if_valid & (not_ready1 | not_ready2);
  assign stall_request = if_valid & ~flush & (hazard | stall_in);

  // Update selection: flush beats stall_in, stall_in (hold) beats hazard.
  assign do_bubble = flush | (~stall_in & (hazard | ~if_valid));
  assign do_load   = ~flush & ~stall_in & ~hazard & if_valid;
  assign do_count  = ~flush & ~stall_in & hazard;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid           <= 1'b0;
      ex_program_counter <= '0;
      ex_alu_operator    <= ALU_NOP;
      ex_alu_category    <= CAT_NOP;
      ex_alu_operand1    <= '0;
      ex_alu_operand2    <= '0;
      ex_write_enable    <= 1'b0;
      ex_write_addr      <= '0;
      ex_invalid         <= 1'b0;
      stall_count        <= '0;
    end else begin
      if (do_bubble) begin
        ex_valid           <= 1'b0;
        ex_program_counter <= '0;
        ex_alu_operator    <= ALU_NOP;
        ex_alu_category    <= CAT_NOP;
        ex_alu_operand1    <= '0;
        ex_alu_operand2    <= '0;
        ex_write_enable    <= 1'b0;
        ex_write_addr      <= '0;
        ex_invalid         <= 1'b0;
      end else if (do_load) begin
        // Unknown encodings decode to NOP with no write, flagged invalid.
        ex_valid           <= 1'b1;
        ex_program_counter <= program_counter;
        ex_alu_operator    <= dec.op;
        ex_alu_category    <= dec.cat;
        ex_alu_operand1    <= operand1;
        ex_alu_operand2    <= operand2;
        ex_write_enable    <= dec.write_en;
        ex_write_addr      <= REG_ADDR_WIDTH'(dec.write_reg);
        ex_invalid         <= ~dec.known;
      end
      if (do_count && stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
